// File: rtl/csr_file_if.sv
// rtl/csr_file_if.sv - EXE-stage to CSR unit signal bundle
//
// Purpose: groups every csr_file signal except clk/rst.
// Ports (slave = csr_file side):
//   in : exe_valid, csr_valid, csr_funct3[2:0], sys_op[1:0], csr_addr[11:0],
//        csr_src[31:0], csr_zimm[4:0], exe_pc[31:0], pipe_hold, retire,
//        ext_irq, timer_irq
//   out: csr_rdata[31:0], redirect, redirect_pc[31:0], wfi_stall
interface csr_file_if;
    logic        exe_valid;
    logic        csr_valid;
    logic [2:0]  csr_funct3;
    logic [1:0]  sys_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_src;
    logic [4:0]  csr_zimm;
    logic [31:0] exe_pc;
    logic        pipe_hold;
    logic        retire;
    logic        ext_irq;
    logic        timer_irq;
    logic [31:0] csr_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        wfi_stall;

    modport master (
        output exe_valid, csr_valid, csr_funct3, sys_op, csr_addr, csr_src,
               csr_zimm, exe_pc, pipe_hold, retire, ext_irq, timer_irq,
        input  csr_rdata, redirect, redirect_pc, wfi_stall
    );

    modport slave (
        input  exe_valid, csr_valid, csr_funct3, sys_op, csr_addr, csr_src,
               csr_zimm, exe_pc, pipe_hold, retire, ext_irq, timer_irq,
        output csr_rdata, redirect, redirect_pc, wfi_stall
    );
endinterface

// File: rtl/csr_file.sv
// rtl/csr_file.sv - RV32 machine-mode CSR unit (Zicsr, MRET, WFI, counters, irq entry)
//
// Ports:
//   clk       : clock
//   rst       : asynchronous active-high reset
//   bus       : csr_file_if.slave (EXE-stage inputs, rdata/redirect/wfi_stall outputs)
// Parameter:
//   RESET_MTVEC : reset value of mtvec (bits [1:0] forced to 0)
// Build option:
//   CSR_WFI_EN  : when defined, WFI sleeps in a RUN/SLEEP FSM until mie & mip
//                 is non-zero; otherwise WFI is a NOP and wfi_stall is 0.
module csr_file #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst,
    csr_file_if.slave  bus
);
    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic        mie_meie;
    logic        mie_mtie;
    logic [31:0] mtvec_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [63:0] mcycle_q;
    logic [63:0] minstret_q;

    logic [31:0] mstatus_val;
    logic [31:0] mie_val;
    logic [31:0] mip_val;
    logic [31:0] old_val;
    logic [31:0] operand;
    logic [31:0] wdata;
    logic        irq_ext;
    logic        irq_tmr;
    logic        take_irq;
    logic        fire;
    logic        csr_we;
    logic        mret;

    assign mstatus_val = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
    assign mie_val     = {20'b0, mie_meie, 3'b0, mie_mtie, 7'b0};
    assign mip_val     = {20'b0, bus.ext_irq, 3'b0, bus.timer_irq, 7'b0};

    always_comb begin
        old_val = 32'h0;
        case (bus.csr_addr)
            12'h300: old_val = mstatus_val;
            12'h304: old_val = mie_val;
            12'h305: old_val = mtvec_q;
            12'h341: old_val = mepc_q;
            12'h342: old_val = mcause_q;
            12'h344: old_val = mip_val;
            12'hB00, 12'hC00: old_val = mcycle_q[31:0];
            12'hB80, 12'hC80: old_val = mcycle_q[63:32];
            12'hB02, 12'hC02: old_val = minstret_q[31:0];
            12'hB82, 12'hC82: old_val = minstret_q[63:32];
            default: old_val = 32'h0;
        endcase
    end

    assign bus.csr_rdata = old_val;

    assign operand = bus.csr_funct3[2] ? {27'b0, bus.csr_zimm} : bus.csr_src;

    always_comb begin
        wdata = old_val;
        case (bus.csr_funct3[1:0])
            2'b01:   wdata = operand;
            2'b10:   wdata = old_val | operand;
            2'b11:   wdata = old_val & ~operand;
            default: wdata = old_val;
        endcase
    end

    // Global MIE gates trap entry; the WFI wake term below deliberately does not.
    assign irq_ext  = mstatus_mie & mie_meie & bus.ext_irq;
    assign irq_tmr  = mstatus_mie & mie_mtie & bus.timer_irq;
    assign take_irq = (irq_ext | irq_tmr) & bus.exe_valid & !bus.pipe_hold;

    // A taken interrupt squashes whatever SYSTEM effect the EXE op would have had.
    assign fire   = bus.csr_valid & !bus.pipe_hold & !take_irq;
    assign csr_we = fire & (bus.csr_funct3[1:0] != 2'b00);
    assign mret   = fire & (bus.csr_funct3 == 3'b000) & (bus.sys_op == 2'b01);

    assign bus.redirect    = take_irq | mret;
    assign bus.redirect_pc = take_irq ? mtvec_q : mepc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_meie     <= 1'b0;
            mie_mtie     <= 1'b0;
            mtvec_q      <= RESET_MTVEC & 32'hFFFF_FFFC;
            mepc_q       <= 32'h0;
            mcause_q     <= 32'h0;
            mcycle_q     <= 64'h0;
            minstret_q   <= 64'h0;
        end else begin
            mcycle_q <= mcycle_q + 64'd1;
            if (bus.retire && !bus.pipe_hold) begin
                minstret_q <= minstret_q + 64'd1;
            end

            if (take_irq) begin
                mepc_q       <= bus.exe_pc & 32'hFFFF_FFFC;
                mcause_q     <= irq_ext ? 32'h8000_000B : 32'h8000_0007;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (mret) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end else if (csr_we) begin
                // Counter-half writes come after the increments so they win,
                // and they keep the other half exactly as it was (no carry).
                case (bus.csr_addr)
                    12'h300: begin
                        mstatus_mie  <= wdata[3];
                        mstatus_mpie <= wdata[7];
                    end
                    12'h304: begin
                        mie_meie <= wdata[11];
                        mie_mtie <= wdata[7];
                    end
                    12'h305: mtvec_q    <= wdata & 32'hFFFF_FFFC;
                    12'h341: mepc_q     <= wdata & 32'hFFFF_FFFC;
                    12'h342: mcause_q   <= wdata;
                    12'hB00: mcycle_q   <= {mcycle_q[63:32], wdata};
                    12'hB80: mcycle_q   <= {wdata, mcycle_q[31:0]};
                    12'hB02: minstret_q <= {minstret_q[63:32], wdata};
                    12'hB82: minstret_q <= {wdata, minstret_q[31:0]};
                    default: ;
                endcase
            end
        end
    end

`ifdef CSR_WFI_EN
    typedef enum logic {RUN, SLEEP} wfi_state_t;
    wfi_state_t state;
    logic       wake;
    logic       wfi_go;

    assign wake   = |(mie_val & mip_val);
    assign wfi_go = fire & (bus.csr_funct3 == 3'b000) & (bus.sys_op == 2'b10);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (wfi_go) state <= SLEEP;
                SLEEP:   if (wake)   state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    assign bus.wfi_stall = (state == SLEEP) & !wake;
`else
    assign bus.wfi_stall = 1'b0;
`endif
endmodule

// File: tb/tb_csr_file.sv
// tb/tb_csr_file.sv - directed self-checking bench for csr_file
module tb_csr_file;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

`ifdef CSR_WFI_EN
    localparam logic EXP_SLEEP = 1'b1;
`else
    localparam logic EXP_SLEEP = 1'b0;
`endif

    csr_file_if bus ();

    csr_file #(.RESET_MTVEC(32'h0000_0403)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [31:0] src;
        logic [4:0]  zimm;
        logic        ext;
        logic        tmr;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start();
        @(negedge clk);
        bus.exe_valid  = 1'b0;
        bus.csr_valid  = 1'b0;
        bus.csr_funct3 = 3'b000;
        bus.sys_op     = 2'b00;
        bus.csr_addr   = 12'h000;
        bus.csr_src    = 32'h0;
        bus.csr_zimm   = 5'd0;
        bus.exe_pc     = 32'h0;
        bus.pipe_hold  = 1'b0;
        bus.retire     = 1'b0;
        bus.ext_irq    = 1'b0;
        bus.timer_irq  = 1'b0;
    endtask

    task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
        start();
        bus.csr_addr = a;
        #1;
        check(name, bus.csr_rdata, exp);
    endtask

    task automatic op(input string name, input logic [2:0] f3, input logic [11:0] a,
                      input logic [31:0] s, input logic [31:0] exp);
        start();
        bus.exe_valid  = 1'b1;
        bus.csr_valid  = 1'b1;
        bus.csr_funct3 = f3;
        bus.csr_addr   = a;
        bus.csr_src    = s;
        #1;
        check(name, bus.csr_rdata, exp);
    endtask

    task automatic sys(input logic [1:0] so, input logic hold);
        start();
        bus.exe_valid  = 1'b1;
        bus.csr_valid  = 1'b1;
        bus.sys_op     = so;
        bus.pipe_hold  = hold;
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        tbl[0]  = '{3'b001, 12'h305, 32'h0000_1003, 5'd0,  1'b0, 1'b0, 32'h0000_0400};
        tbl[1]  = '{3'b010, 12'h305, 32'h0,         5'd0,  1'b0, 1'b0, 32'h0000_1000};
        tbl[2]  = '{3'b110, 12'h305, 32'hFFFF_FFFF, 5'h10, 1'b0, 1'b0, 32'h0000_1000};
        tbl[3]  = '{3'b111, 12'h305, 32'hFFFF_FFFF, 5'h10, 1'b0, 1'b0, 32'h0000_1010};
        tbl[4]  = '{3'b010, 12'h305, 32'h0,         5'd0,  1'b0, 1'b0, 32'h0000_1000};
        tbl[5]  = '{3'b001, 12'h304, 32'hFFFF_FFFF, 5'd0,  1'b0, 1'b0, 32'h0};
        tbl[6]  = '{3'b010, 12'h304, 32'h0,         5'd0,  1'b0, 1'b0, 32'h0000_0880};
        tbl[7]  = '{3'b011, 12'h304, 32'h0000_0080, 5'd0,  1'b0, 1'b0, 32'h0000_0880};
        tbl[8]  = '{3'b010, 12'h304, 32'h0,         5'd0,  1'b0, 1'b0, 32'h0000_0800};
        tbl[9]  = '{3'b001, 12'h341, 32'h1234_5677, 5'd0,  1'b0, 1'b0, 32'h0};
        tbl[10] = '{3'b010, 12'h341, 32'h0,         5'd0,  1'b0, 1'b0, 32'h1234_5674};
        tbl[11] = '{3'b001, 12'h342, 32'hDEAD_BEEF, 5'd0,  1'b0, 1'b0, 32'h0};
        tbl[12] = '{3'b101, 12'h342, 32'hFFFF_FFFF, 5'd5,  1'b0, 1'b0, 32'hDEAD_BEEF};
        tbl[13] = '{3'b010, 12'h342, 32'h0,         5'd0,  1'b0, 1'b0, 32'h0000_0005};
        tbl[14] = '{3'b001, 12'h300, 32'h0000_0088, 5'd0,  1'b0, 1'b0, 32'h0000_1800};
        tbl[15] = '{3'b011, 12'h300, 32'hFFFF_FFFF, 5'd0,  1'b0, 1'b0, 32'h0000_1888};
        tbl[16] = '{3'b010, 12'h300, 32'h0,         5'd0,  1'b0, 1'b0, 32'h0000_1800};
        tbl[17] = '{3'b001, 12'h123, 32'h0000_FFFF, 5'd0,  1'b0, 1'b0, 32'h0};
        tbl[18] = '{3'b010, 12'h123, 32'h0,         5'd0,  1'b0, 1'b0, 32'h0};
        tbl[19] = '{3'b010, 12'h344, 32'hFFFF_FFFF, 5'd0,  1'b1, 1'b1, 32'h0000_0880};
        tbl[20] = '{3'b010, 12'h344, 32'h0,         5'd0,  1'b0, 1'b0, 32'h0};

        // Reset state
        rd("rst_mstatus", 12'h300, 32'h0000_1800);
        rd("rst_mie",     12'h304, 32'h0);
        rd("rst_mtvec",   12'h305, 32'h0000_0400);
        rd("rst_mepc",    12'h341, 32'h0);
        rd("rst_mcause",  12'h342, 32'h0);
        rd("rst_mcycle",  12'hB00, 32'h0);
        rd("rst_minstrh", 12'hB82, 32'h0);
        check("rst_redirect", {31'b0, bus.redirect}, 32'h0);
        check("rst_wfi_stall", {31'b0, bus.wfi_stall}, 32'h0);

        // Cycle counter
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        op("cycle_10", 3'b001, 12'hC00, 32'h0, 32'd10);
        rd("cycle_ro",   12'hC00, 32'd11);
        rd("mcycle_12",  12'hB00, 32'd12);
        rd("cycleh_0",   12'hC80, 32'd0);
        op("mcycle_wr",  3'b001, 12'hB00, 32'd100, 32'd14);
        rd("mcycle_win", 12'hB00, 32'd100);
        rd("mcycle_inc", 12'hB00, 32'd101);
        op("mcycleh_wr", 3'b001, 12'hB80, 32'd5, 32'd0);
        rd("mcycle_lo_kept", 12'hC00, 32'd102);
        rd("mcycleh_5",  12'hC80, 32'd5);

        // instret gating: two of five retires held off
        for (int i = 0; i < 5; i++) begin
            start();
            bus.retire    = 1'b1;
            bus.pipe_hold = (i == 1 || i == 3);
        end
        rd("instret_3",  12'hC02, 32'd3);
        rd("instreth_0", 12'hB82, 32'd0);

        // instret carry and write-wins
        op("minstret_wr", 3'b001, 12'hB02, 32'hFFFF_FFFF, 32'd3);
        start();
        bus.retire = 1'b1;
        rd("minstret_wrap", 12'hB02, 32'd0);
        rd("minstreth_1",   12'hB82, 32'd1);
        rd("instreth_1",    12'hC82, 32'd1);
        start();
        bus.exe_valid  = 1'b1;
        bus.csr_valid  = 1'b1;
        bus.csr_funct3 = 3'b001;
        bus.csr_addr   = 12'hB02;
        bus.csr_src    = 32'd7;
        bus.retire     = 1'b1;
        rd("minstret_win", 12'hC02, 32'd7);
        rd("minstreth_kept", 12'hB82, 32'd1);

        // Table-driven CSR read/modify/write
        for (int i = 0; i < 21; i++) begin
            start();
            bus.exe_valid  = 1'b1;
            bus.csr_valid  = 1'b1;
            bus.csr_funct3 = tbl[i].f3;
            bus.csr_addr   = tbl[i].addr;
            bus.csr_src    = tbl[i].src;
            bus.csr_zimm   = tbl[i].zimm;
            bus.ext_irq    = tbl[i].ext;
            bus.timer_irq  = tbl[i].tmr;
            #1;
            check($sformatf("tbl%0d_rdata", i), bus.csr_rdata, tbl[i].exp);
            check($sformatf("tbl%0d_redir", i), {31'b0, bus.redirect}, 32'h0);
        end

        // Interrupt entry and MRET
        op("mtvec_set", 3'b001, 12'h305, 32'h100, 32'h0000_1000);
        op("mie_on",    3'b010, 12'h300, 32'h8,   32'h0000_1800);
        start();
        bus.exe_valid = 1'b1;
        bus.ext_irq   = 1'b1;
        bus.pipe_hold = 1'b1;
        bus.exe_pc    = 32'h300;
        #1;
        check("irq_held", {31'b0, bus.redirect}, 32'h0);
        start();
        bus.ext_irq = 1'b1;
        #1;
        check("irq_no_valid", {31'b0, bus.redirect}, 32'h0);
        start();
        bus.exe_valid = 1'b1;
        bus.ext_irq   = 1'b1;
        bus.exe_pc    = 32'h200;
        #1;
        check("irq_redirect", {31'b0, bus.redirect}, 32'h1);
        check("irq_pc",       bus.redirect_pc, 32'h100);
        rd("irq_mepc",    12'h341, 32'h200);
        rd("irq_mcause",  12'h342, 32'h8000_000B);
        rd("irq_mstatus", 12'h300, 32'h0000_1880);
        sys(2'b01, 1'b0);
        check("mret_redirect", {31'b0, bus.redirect}, 32'h1);
        check("mret_pc",       bus.redirect_pc, 32'h200);
        rd("mret_mstatus", 12'h300, 32'h0000_1888);

        // Timer cause, and external priority
        op("mie_both", 3'b001, 12'h304, 32'h880, 32'h0000_0800);
        start();
        bus.exe_valid = 1'b1;
        bus.timer_irq = 1'b1;
        bus.exe_pc    = 32'h404;
        #1;
        check("tmr_redirect", {31'b0, bus.redirect}, 32'h1);
        rd("tmr_mcause", 12'h342, 32'h8000_0007);
        rd("tmr_mepc",   12'h341, 32'h404);
        sys(2'b01, 1'b0);
        check("mret2_pc", bus.redirect_pc, 32'h404);
        start();
        bus.exe_valid = 1'b1;
        bus.timer_irq = 1'b1;
        bus.ext_irq   = 1'b1;
        bus.exe_pc    = 32'h208;
        #1;
        check("prio_redirect", {31'b0, bus.redirect}, 32'h1);
        rd("prio_mcause", 12'h342, 32'h8000_000B);
        sys(2'b01, 1'b0);

        // Interrupt wins over a CSR write in the same cycle
        start();
        bus.exe_valid  = 1'b1;
        bus.csr_valid  = 1'b1;
        bus.csr_funct3 = 3'b001;
        bus.csr_addr   = 12'h305;
        bus.csr_src    = 32'h500;
        bus.ext_irq    = 1'b1;
        bus.exe_pc     = 32'h20C;
        #1;
        check("irqwr_redirect", {31'b0, bus.redirect}, 32'h1);
        check("irqwr_pc",       bus.redirect_pc, 32'h100);
        check("irqwr_rdata",    bus.csr_rdata, 32'h100);
        rd("irqwr_mtvec_kept", 12'h305, 32'h100);
        rd("irqwr_mepc",       12'h341, 32'h20C);
        sys(2'b01, 1'b0);
        start();
        bus.exe_valid  = 1'b1;
        bus.csr_valid  = 1'b1;
        bus.csr_funct3 = 3'b001;
        bus.csr_addr   = 12'h340;
        bus.csr_src    = 32'h1;
        bus.ext_irq    = 1'b1;
        bus.exe_pc     = 32'h210;
        #1;
        check("irq340_redirect", {31'b0, bus.redirect}, 32'h1);
        rd("irq340_read", 12'h340, 32'h0);
        rd("irq340_mstatus", 12'h300, 32'h0000_1880);

        // WFI with MIE = 0, MTIE = 1
        op("mie_mtie", 3'b001, 12'h304, 32'h80, 32'h0000_0880);
        sys(2'b10, 1'b1);
        start();
        #1;
        check("wfi_held_nosleep", {31'b0, bus.wfi_stall}, 32'h0);
        sys(2'b10, 1'b0);
        check("wfi_issue_cycle", {31'b0, bus.wfi_stall}, 32'h0);
        start();
        #1;
        check("wfi_sleep1", {31'b0, bus.wfi_stall}, {31'b0, EXP_SLEEP});
        start();
        bus.ext_irq = 1'b1;
        #1;
        check("wfi_ext_masked", {31'b0, bus.wfi_stall}, {31'b0, EXP_SLEEP});
        start();
        bus.timer_irq = 1'b1;
        #1;
        check("wfi_wake_stall", {31'b0, bus.wfi_stall}, 32'h0);
        check("wfi_wake_noredir", {31'b0, bus.redirect}, 32'h0);
        start();
        #1;
        check("wfi_back_run", {31'b0, bus.wfi_stall}, 32'h0);

        // Reset during SLEEP
        sys(2'b10, 1'b0);
        start();
        bus.csr_addr = 12'h305;
        #1;
        check("wfi_sleep2", {31'b0, bus.wfi_stall}, {31'b0, EXP_SLEEP});
        rst = 1'b1;
        #1;
        check("rst_sleep_stall", {31'b0, bus.wfi_stall}, 32'h0);
        check("rst_sleep_mtvec", bus.csr_rdata, 32'h0000_0400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/csr_file.md
# csr_file

Machine-mode CSR unit for the RV32 core, located in the EXE stage directly downstream of the instruction decoder. It executes the Zicsr read/modify/write operations, MRET and WFI. It owns the 64-bit cycle and instret counters, the machine trap CSRs and the external/timer interrupt entry. It drives the PC-redirect path into IF and the WFI pipeline stall.

## Interface
Parameters:
- `RESET_MTVEC`, default `32'h0000_0000`: reset value of `mtvec`, bits [1:0] forced to 0.

Ports:
- `clk` input, 1 bit: clock.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `exe_valid` input, 1 bit: EXE holds a real (unflushed) instruction.
- `csr_valid` input, 1 bit: EXE instruction is a SYSTEM/CSR op (implies `exe_valid`).
- `csr_funct3` input, 3 bits: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI, 000 selects `sys_op`.
- `sys_op` input, 2 bits: 00 none, 01 MRET, 10 WFI.
- `csr_addr` input, 12 bits: CSR address.
- `csr_src` input, 32 bits: rs1 value.
- `csr_zimm` input, 5 bits: immediate, zero-extended.
- `exe_pc` input, 32 bits: PC of the EXE instruction.
- `pipe_hold` input, 1 bit: ID_stall | AXI_stall. Freezes all architectural updates except `mcycle`.
- `retire` input, 1 bit: one instruction retired this cycle.
- `ext_irq` input, 1 bit: level-sensitive external interrupt.
- `timer_irq` input, 1 bit: level-sensitive timer interrupt.
- `csr_rdata` output, 32 bits: old value of the addressed CSR (rd writeback).
- `redirect` output, 1 bit: flush the pipeline and fetch from `redirect_pc`.
- `redirect_pc` output, 32 bits: redirect target.
- `wfi_stall` output, 1 bit: hold the whole pipeline.

## Operation
CSR map:
- `mstatus` 0x300: MIE is bit 3, MPIE is bit 7, MPP[12:11] reads 2'b11. All other bits read 0.
- `mie` 0x304: MEIE is bit 11, MTIE is bit 7.
- `mtvec` 0x305 (direct mode only) and `mepc` 0x341: bits [1:0] read 0.
- `mcause` 0x342.
- `mip` 0x344: read-only; MEIP = `ext_irq`, MTIP = `timer_irq`.
- `mcycle`/`mcycleh` 0xB00/0xB80 and `minstret`/`minstreth` 0xB02/0xB82: read/write.
- `cycle`/`cycleh`/`instret`/`instreth` 0xC00/0xC80/0xC02/0xC82: read-only shadows.
- Unmapped addresses read 0; writes to them are ignored.

CSR operations:
- The operand is `csr_src` for RW/RS/RC and `csr_zimm` for the immediate forms.
- New value: RW writes the operand, RS writes old | operand, RC writes old & ~operand.
- A write is committed when `csr_valid & !pipe_hold` and no interrupt is taken.
- `csr_rdata` is combinational from the addressed CSR and always shows the pre-write value.

Counters:
- `mcycle` increments every cycle, including cycles with `pipe_hold` or `wfi_stall` asserted.
- `minstret` increments when `retire & !pipe_hold`.
- Both wrap modulo 2^64 with carry between the halves.
- A CSR write to either half wins over that counter's increment in the same cycle. The other half is unchanged.

Interrupts:
- `irq_pend = MIE & ((MEIE & ext_irq) | (MTIE & timer_irq))`.
- An interrupt is taken when `irq_pend & exe_valid & !pipe_hold`. When taken:
  - `mepc` ← `exe_pc`; the EXE instruction is not executed and its CSR/MRET/WFI effect is suppressed.
  - `mcause` ← 0x8000000B (external) or 0x80000007 (timer); external has priority.
  - MPIE ← MIE, MIE ← 0.
  - `redirect` = 1, `redirect_pc` = `mtvec`.
- MRET (`csr_valid & sys_op==01 & !pipe_hold`, no interrupt taken): MIE ← MPIE, MPIE ← 1, `redirect` = 1, `redirect_pc` = `mepc`.
- Priority: interrupt, then MRET/WFI/CSR write.

WFI FSM, states RUN and SLEEP:
- RUN → SLEEP when `csr_valid & sys_op==10 & !pipe_hold` and no interrupt is taken.
- In SLEEP, `wake = |(mie & mip)`, independent of MIE.
- `wfi_stall = SLEEP & !wake`.
- SLEEP → RUN when `wake` is set.
- In the wake cycle the normal interrupt rule applies. If MIE = 0, execution resumes after the WFI with no redirect.

## Timing
- `csr_rdata`, `redirect`, `redirect_pc` and `wfi_stall` are combinational, valid in the cycle of the event.
- State updates at the next rising edge. A CSR written at edge N reads back the new value from cycle N+1.
- Reset values: all CSRs 0 except `mtvec` = `RESET_MTVEC`; FSM in RUN; `redirect` = 0; `wfi_stall` = 0.
- `rst` asserted during SLEEP returns the FSM to RUN immediately.
- `mcycle` counts rising edges after `rst` is released.

## Configuration
- `CSR_WFI_EN` defined: the WFI FSM is implemented as described above.
- `CSR_WFI_EN` undefined: no FSM, WFI executes as a NOP, and `wfi_stall` is tied to 0.

## Test plan
1. **Cycle counter:** release reset, wait 10 edges, read 0xC00 → 10; write 0xC00 → value unchanged.
2. **mtvec write:** CSRRW 0x305 with 0x00001003 → `csr_rdata` = 0; next read returns 0x00001000.
3. **instret gating:** 5 `retire` pulses, 2 of them with `pipe_hold` = 1 → `minstret` = 3.
4. **instret carry:** CSRRW 0xB02 = 0xFFFFFFFF, then one retire → 0xB02 = 0, 0xB82 = 1.
5. **Interrupt and MRET:** `mtvec` = 0x100, MEIE = 1, MIE = 1, `ext_irq` = 1 with `exe_pc` = 0x200 → `redirect` to 0x100, `mepc` = 0x200, `mcause` = 0x8000000B, MIE = 0, MPIE = 1. Then MRET → `redirect` to 0x200, MIE = 1.
6. **WFI wake without trap:** MIE = 0, MTIE = 1, issue WFI → `wfi_stall` = 1 from the next cycle. Raise `timer_irq` → `wfi_stall` = 0 in the same cycle, no redirect.
7. **Interrupt vs CSR write:** CSRRW 0x340 and an interrupt in the same cycle → write suppressed, `redirect` asserted.
